exact_matcher_nway: RTL and testbench
=====================================

Name: exact_matcher_nway

Overview:
- Parametrised successor of the single-way exact-match lookup.
- On `start_i`, reads a key of configurable byte length from packet memory and hashes it via `matcher_hash`.
- Scans a WAYS-deep bucket in table memory, stops at the first valid entry whose key matches, and returns hit, way and value address.
- Table layout and key location come from runtime config ports, so one instance serves any table in the pipeline.

Parameters:
- ADDR_W, 32, memory address width
- MAX_KEY_BYTES, 8, largest supported key; key register is MAX_KEY_BYTES*8 bits
- WAYS, 4, entries per hash bucket (power of two, >=1)
- IDX_W, 4, bucket index bits taken from hash (table has 2^IDX_W buckets)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  level request; held until ready_o seen, then dropped
- cfg_hdr_base_i  in  ADDR_W  packet base byte address of header
- cfg_key_off_i  in  8  key offset (bytes) within header
- cfg_key_len_i  in  4  key length in bytes, legal 1..MAX_KEY_BYTES
- cfg_entry_len_i  in  16  entry stride in bytes
- cfg_tab_base_i  in  ADDR_W  table start address
- mem_ce_o  out  1  read enable
- mem_addr_o  out  ADDR_W  byte read address
- mem_data_i  in  8  read byte, valid the cycle after mem_ce_o/addr
- ready_o  out  1  result valid, held in DONE
- hit_o  out  1  match found
- err_o  out  1  illegal cfg_key_len_i
- way_o  out  clog2(WAYS) max 1  matching way
- val_addr_o  out  ADDR_W  value address on hit, 0 on miss

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0, key register cleared, state FREE. Reset mid-operation aborts immediately; mem_ce_o is 0 on the next cycle.
- Config is sampled into registers on FREE->LOAD_KEY and ignored thereafter.
- Memory reads are pipelined: address issued in cycle N, byte captured in N+1. A separate issue counter and capture counter are kept.
- FREE: on start_i=1, clear ready_o, hit_o, err_o, val_addr_o, way_o.
  - If key_len is 0 or >MAX_KEY_BYTES: err_o=1, ready_o=1, go to DONE.
  - Otherwise go to LOAD_KEY.
- LOAD_KEY: issue addresses hdr_base+key_off+i for i=0..key_len-1, one per cycle. Byte i lands in key[MAX*8-1-8i -: 8] (MSB-first); unused low bytes stay 0. After the last capture (key_len+1 cycles), pulse hash start and go to HASH.
- HASH: wait for hash ready. Then bucket = tab_base + idx*WAYS*entry_len (full ADDR_W, wraps modulo 2^ADDR_W). way=0, go to LOAD_ENTRY.
- LOAD_ENTRY: entry base E = bucket + way*entry_len.
  - Read E (valid byte) and E+1..E+key_len (key bytes), pipelined: key_len+2 cycles.
  - Match = valid byte bit0 set and all key_len bytes equal.
  - On match: hit_o=1, way_o=way, val_addr_o=E+1+key_len, go to DONE.
  - On no match with way=WAYS-1: miss, hit_o=0, val_addr_o=0, go to DONE.
  - Otherwise way+1 and stay in LOAD_ENTRY.
- DONE: ready_o=1, mem_ce_o=0. When start_i=0, go to FREE (ready_o stays until the next start).
- start_i dropping before DONE is ignored; the lookup completes.
- mem_ce_o is high only while addresses are being issued.

Optional Feature:
- MATCHER_STATS_EN defined: adds outputs hit_cnt_o and miss_cnt_o (32 bits each). Each increments by one on entry to DONE, according to the result. Both saturate at 0xFFFFFFFF, are cleared by reset, and err lookups count in neither.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/header `def.vh`: state encodings MT2_STATE_FREE/LOAD_KEY/HASH/LOAD_ENTRY/DONE, TRUE/FALSE, zero constants.
- Sub-module `matcher_hash`:
  - Function: fold = key[63:32]^key[31:0] (upper half zero-extended if MAX<8), idx = fold[IDX_W-1:0].
  - Handshake: ready_o rises one cycle after start_i is sampled and holds while start_i=1.

Test Plan:
- Hit in way 0: hdr_base=14, key_off=16, key_len=4, entry_len=16, tab_base=128; packet bytes 30..33 = 0A 00 00 01 give idx=1, bucket 192. Entry 192 = {01,0A,00,00,01} -> hit_o=1, way_o=0, val_addr_o=197.
- Hit in way 2: same key, ways 0..1 valid with wrong keys, way 2 at 224 matching -> hit_o=1, way_o=2, val_addr_o=229.
- Miss and invalid skip: all four ways either valid-bit 0 or mismatching -> ready_o=1, hit_o=0, val_addr_o=0; mem_ce_o low in DONE.
- Illegal length: key_len=0, then key_len=9 -> err_o=1, ready_o=1 within 2 cycles, no mem_ce_o pulses.
- Reset mid-lookup: rst_n=0 during LOAD_ENTRY -> next cycle all outputs 0, mem_ce_o=0; a fresh lookup then matches the first test.
- Stats (MATCHER_STATS_EN): 3 hits, 2 misses, 1 err -> hit_cnt_o=3, miss_cnt_o=2.

Source files
------------

// File: rtl/exact_matcher_nway_pkg.sv
// Shared definitions for the N-way exact-match lookup: FSM states and the key fold.
package exact_matcher_nway_pkg;

    typedef enum logic [2:0] {
        ST_FREE,
        ST_LOAD_KEY,
        ST_HASH,
        ST_LOAD_ENTRY,
        ST_DONE
    } state_t;

    localparam int unsigned FOLD_IN_W = 64;

    function automatic logic [31:0] fold64(input logic [FOLD_IN_W-1:0] k);
        return k[63:32] ^ k[31:0];
    endfunction

endpackage

// File: rtl/exact_matcher_nway_hash.sv
// matcher_hash: folds the key into a bucket index; ready follows start by one cycle.
module matcher_hash
    import exact_matcher_nway_pkg::*;
#(
    parameter int unsigned KEY_W = 64,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             ready_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int unsigned PAD_W = (KEY_W < FOLD_IN_W) ? FOLD_IN_W : KEY_W;

    logic [PAD_W-1:0] w_key_pad;
    logic             r_ready;
    logic [IDX_W-1:0] r_idx;

    // Narrow keys are zero-extended so the upper fold half is zero.
    assign w_key_pad = PAD_W'(key_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_ready <= start_i;
            if (start_i) begin
                r_idx <= IDX_W'(fold64(w_key_pad[FOLD_IN_W-1:0]));
            end
        end
    end

    assign ready_o = r_ready;
    assign idx_o   = r_idx;

endmodule

// File: rtl/exact_matcher_nway.sv
// N-way exact-match lookup: key fetch, hash, bucket scan over pipelined byte memory.
// Optional MATCHER_STATS_EN adds saturating hit/miss counters.
module exact_matcher_nway
    import exact_matcher_nway_pkg::*;
#(
    parameter  int unsigned ADDR_W        = 32,
    parameter  int unsigned MAX_KEY_BYTES = 8,
    parameter  int unsigned WAYS          = 4,
    parameter  int unsigned IDX_W         = 4,
    localparam int unsigned WAY_W         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] cfg_hdr_base_i,
    input  logic [7:0]        cfg_key_off_i,
    input  logic [3:0]        cfg_key_len_i,
    input  logic [15:0]       cfg_entry_len_i,
    input  logic [ADDR_W-1:0] cfg_tab_base_i,
    output logic              mem_ce_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic              ready_o,
    output logic              hit_o,
    output logic              err_o,
    output logic [WAY_W-1:0]  way_o,
    output logic [ADDR_W-1:0] val_addr_o
`ifdef MATCHER_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned KEY_W = MAX_KEY_BYTES * 8;
    localparam int unsigned KB_W  = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_key_addr;
    logic [3:0]        r_key_len;
    logic [15:0]       r_entry_len;
    logic [ADDR_W-1:0] r_tab_base;
    logic [ADDR_W-1:0] r_ebase;
    logic [4:0]        r_iss;
    logic [4:0]        r_cap;
    logic              r_pend;
    logic              r_match;
    logic              r_hash_start;
    logic [WAY_W-1:0]  r_way;
    logic [7:0]        r_key_b [MAX_KEY_BYTES];

    logic              r_ready;
    logic              r_hit;
    logic              r_err;
    logic [WAY_W-1:0]  r_way_out;
    logic [ADDR_W-1:0] r_val_addr;

    logic [KEY_W-1:0]  w_key;
    logic              w_len_ok;
    logic              w_ce;
    logic [ADDR_W-1:0] w_addr;
    logic              w_hash_ready;
    logic [IDX_W-1:0]  w_hash_idx;
    logic [ADDR_W-1:0] w_bucket;
    logic [4:0]        w_len5;
    logic              w_key_last;
    logic              w_ent_last;
    logic              w_byte_eq;
    logic              w_ent_match;
    logic              w_last_way;
    logic              w_done_hit;
    logic              w_done_miss;

    assign w_len_ok = (cfg_key_len_i != 4'd0) && (32'(cfg_key_len_i) <= MAX_KEY_BYTES);
    assign w_len5   = {1'b0, r_key_len};

    // Byte 0 of the key is the most significant byte of the packed register.
    always_comb begin
        w_key = '0;
        for (int unsigned b = 0; b < MAX_KEY_BYTES; b++) begin
            w_key[(MAX_KEY_BYTES-1-b)*8 +: 8] = r_key_b[b];
        end
    end

    matcher_hash #(
        .KEY_W (KEY_W),
        .IDX_W (IDX_W)
    ) u_hash (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (r_hash_start),
        .key_i   (w_key),
        .ready_o (w_hash_ready),
        .idx_o   (w_hash_idx)
    );

    assign w_bucket = r_tab_base
                    + ADDR_W'(w_hash_idx) * ADDR_W'(WAYS) * ADDR_W'(r_entry_len);

    // Captures trail issues by one cycle; capture 0 of an entry is its valid byte.
    assign w_key_last  = r_pend && (r_cap == (w_len5 - 5'd1));
    assign w_ent_last  = r_pend && (r_cap == w_len5);
    assign w_byte_eq   = (mem_data_i == r_key_b[KB_W'(r_cap - 5'd1)]);
    assign w_ent_match = r_match && w_byte_eq;
    assign w_last_way  = (r_way == WAY_W'(WAYS - 1));
    assign w_done_hit  = (r_state == ST_LOAD_ENTRY) && w_ent_last && w_ent_match;
    assign w_done_miss = (r_state == ST_LOAD_ENTRY) && w_ent_last && !w_ent_match && w_last_way;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ce        = 1'b0;
        w_addr      = '0;
        case (r_state)
            ST_FREE: begin
                if (start_i) begin
                    w_state_nxt = w_len_ok ? ST_LOAD_KEY : ST_DONE;
                end
            end
            ST_LOAD_KEY: begin
                if (r_iss < w_len5) begin
                    w_ce   = 1'b1;
                    w_addr = r_key_addr + ADDR_W'(r_iss);
                end
                if (w_key_last) begin
                    w_state_nxt = ST_HASH;
                end
            end
            ST_HASH: begin
                if (w_hash_ready) begin
                    w_state_nxt = ST_LOAD_ENTRY;
                end
            end
            ST_LOAD_ENTRY: begin
                if (r_iss <= w_len5) begin
                    w_ce   = 1'b1;
                    w_addr = r_ebase + ADDR_W'(r_iss);
                end
                if (w_done_hit || w_done_miss) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_i) begin
                    w_state_nxt = ST_FREE;
                end
            end
            default: w_state_nxt = ST_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_addr   <= '0;
            r_key_len    <= '0;
            r_entry_len  <= '0;
            r_tab_base   <= '0;
            r_ebase      <= '0;
            r_iss        <= '0;
            r_cap        <= '0;
            r_pend       <= 1'b0;
            r_match      <= 1'b0;
            r_hash_start <= 1'b0;
            r_way        <= '0;
            r_key_b      <= '{default: '0};
            r_ready      <= 1'b0;
            r_hit        <= 1'b0;
            r_err        <= 1'b0;
            r_way_out    <= '0;
            r_val_addr   <= '0;
        end else begin
            r_pend       <= w_ce;
            r_hash_start <= 1'b0;
            case (r_state)
                ST_FREE: begin
                    if (start_i) begin
                        r_ready     <= !w_len_ok;
                        r_err       <= !w_len_ok;
                        r_hit       <= 1'b0;
                        r_way_out   <= '0;
                        r_val_addr  <= '0;
                        r_key_addr  <= cfg_hdr_base_i + ADDR_W'(cfg_key_off_i);
                        r_key_len   <= cfg_key_len_i;
                        r_entry_len <= cfg_entry_len_i;
                        r_tab_base  <= cfg_tab_base_i;
                        r_key_b     <= '{default: '0};
                        r_iss       <= '0;
                        r_cap       <= '0;
                    end
                end
                ST_LOAD_KEY: begin
                    if (w_ce) begin
                        r_iss <= r_iss + 5'd1;
                    end
                    if (r_pend) begin
                        r_key_b[KB_W'(r_cap)] <= mem_data_i;
                        r_cap                 <= r_cap + 5'd1;
                    end
                    if (w_key_last) begin
                        r_hash_start <= 1'b1;
                    end
                end
                ST_HASH: begin
                    if (w_hash_ready) begin
                        r_ebase <= w_bucket;
                        r_way   <= '0;
                        r_iss   <= '0;
                        r_cap   <= '0;
                    end
                end
                ST_LOAD_ENTRY: begin
                    if (w_ce) begin
                        r_iss <= r_iss + 5'd1;
                    end
                    if (r_pend) begin
                        r_cap   <= r_cap + 5'd1;
                        r_match <= (r_cap == 5'd0) ? mem_data_i[0] : (r_match && w_byte_eq);
                    end
                    if (w_done_hit) begin
                        r_ready    <= 1'b1;
                        r_hit      <= 1'b1;
                        r_way_out  <= r_way;
                        r_val_addr <= r_ebase + ADDR_W'(r_key_len) + ADDR_W'(1);
                    end else if (w_done_miss) begin
                        r_ready    <= 1'b1;
                        r_hit      <= 1'b0;
                        r_val_addr <= '0;
                    end else if (w_ent_last) begin
                        r_way   <= r_way + WAY_W'(1);
                        r_ebase <= r_ebase + ADDR_W'(r_entry_len);
                        r_iss   <= '0;
                        r_cap   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MATCHER_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_done_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_done_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    // Counters absent; lookup path is identical.
`endif

    assign mem_ce_o   = w_ce;
    assign mem_addr_o = w_addr;
    assign ready_o    = r_ready;
    assign hit_o      = r_hit;
    assign err_o      = r_err;
    assign way_o      = r_way_out;
    assign val_addr_o = r_val_addr;

endmodule

// File: tb/tb_exact_matcher_nway.sv
// Self-checking bench for exact_matcher_nway: directed cases plus randomized lookups vs a behavioural model.
module tb_exact_matcher_nway;

    localparam int unsigned WAYS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] cfg_hdr_base_i;
    logic [7:0]  cfg_key_off_i;
    logic [3:0]  cfg_key_len_i;
    logic [15:0] cfg_entry_len_i;
    logic [31:0] cfg_tab_base_i;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_data_i = 8'h00;
    logic        ready_o;
    logic        hit_o;
    logic        err_o;
    logic [1:0]  way_o;
    logic [31:0] val_addr_o;
`ifdef MATCHER_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    exact_matcher_nway #(
        .ADDR_W        (32),
        .MAX_KEY_BYTES (8),
        .WAYS          (WAYS),
        .IDX_W         (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .cfg_hdr_base_i  (cfg_hdr_base_i),
        .cfg_key_off_i   (cfg_key_off_i),
        .cfg_key_len_i   (cfg_key_len_i),
        .cfg_entry_len_i (cfg_entry_len_i),
        .cfg_tab_base_i  (cfg_tab_base_i),
        .mem_ce_o        (mem_ce_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_i      (mem_data_i),
        .ready_o         (ready_o),
        .hit_o           (hit_o),
        .err_o           (err_o),
        .way_o           (way_o),
        .val_addr_o      (val_addr_o)
`ifdef MATCHER_STATS_EN
        ,
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [4096];

    always @(posedge clk) begin
        if (mem_ce_o) mem_data_i <= mem[mem_addr_o[11:0]];
    end

    int errors = 0;
    int checks = 0;

    logic        chk_on = 1'b0;
    logic        exp_err;
    logic        exp_hit;
    logic [1:0]  exp_way;
    logic [31:0] exp_val;
    int          exp_nce;
    int          last_n;
    int          hit_exp = 0;
    int          miss_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem[a[11:0]];
    endfunction

    function automatic logic [31:0] bucket_of(input logic [31:0] ka, input logic [3:0] len,
                                              input logic [15:0] elen, input logic [31:0] tab);
        logic [63:0] k;
        logic [31:0] f;
        k = '0;
        for (int i = 0; i < int'(len); i++) k = k | (64'(rd(ka + 32'(i))) << (56 - 8 * i));
        f = k[63:32] ^ k[31:0];
        return tab + (f % 32'd16) * WAYS * 32'(elen);
    endfunction

    // Expected result of one lookup straight from the table rules, plus expected read count.
    function automatic void model(input logic [31:0] ka, input logic [3:0] len, input logic [15:0] elen,
                                  input logic [31:0] tab, output logic e, output logic h,
                                  output logic [1:0] w, output logic [31:0] v, output int nce);
        logic [31:0] eb;
        logic [7:0]  vb;
        logic        ok;
        e = 1'b0; h = 1'b0; w = 2'd0; v = 32'd0; nce = 0;
        if (len == 4'd0 || len > 4'd8) begin
            e = 1'b1;
            return;
        end
        nce = int'(len);
        for (int wi = 0; wi < int'(WAYS); wi++) begin
            eb  = bucket_of(ka, len, elen, tab) + 32'(wi) * 32'(elen);
            nce = nce + int'(len) + 1;
            vb  = rd(eb);
            ok  = vb[0];
            for (int j = 0; j < int'(len); j++) begin
                if (rd(eb + 32'd1 + 32'(j)) != rd(ka + 32'(j))) ok = 1'b0;
            end
            if (ok) begin
                h = 1'b1;
                w = 2'(wi);
                v = eb + 32'd1 + 32'(len);
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("ready_held", 32'(ready_o), 32'd1);
            check("err", 32'(err_o), 32'(exp_err));
            check("hit", 32'(hit_o), 32'(exp_hit));
            check("way", 32'(way_o), 32'(exp_way));
            check("val_addr", val_addr_o, exp_val);
            check("ce_idle", 32'(mem_ce_o), 32'd0);
        end
    end

    task automatic lookup(input logic [31:0] hdr, input logic [7:0] off, input logic [3:0] len,
                          input logic [15:0] elen, input logic [31:0] tab);
        int n;
        int ce_cnt;
        model(hdr + 32'(off), len, elen, tab, exp_err, exp_hit, exp_way, exp_val, exp_nce);
        cfg_hdr_base_i  = hdr;
        cfg_key_off_i   = off;
        cfg_key_len_i   = len;
        cfg_entry_len_i = elen;
        cfg_tab_base_i  = tab;
        start_i = 1'b1;
        ce_cnt = 0;
        @(posedge clk); #1;
        n = 1;
        while (!ready_o && n < 2000) begin
            if (mem_ce_o) ce_cnt++;
            @(posedge clk); #1;
            n++;
        end
        last_n = n;
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready after %0d cycles", n);
        end else begin
            check("read_count", 32'(ce_cnt), 32'(exp_nce));
            chk_on = 1'b1;
        end
        if (exp_hit) hit_exp++;
        else if (!exp_err) miss_exp++;
        start_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk_on = 1'b0;
    endtask

    task automatic put_entry(input int a, input logic [7:0] v, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        mem[a] = v; mem[a+1] = b0; mem[a+2] = b1; mem[a+3] = b2; mem[a+4] = b3;
    endtask

    task automatic setup_base();
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[30] = 8'h0A; mem[31] = 8'h00; mem[32] = 8'h00; mem[33] = 8'h01;
    endtask

    initial begin
        logic [31:0] hdr, tab, eb;
        logic [7:0]  off;
        logic [3:0]  len;
        logic [15:0] elen;
        int          n;

        rst_n = 1'b0; start_i = 1'b0;
        cfg_hdr_base_i = '0; cfg_key_off_i = '0; cfg_key_len_i = '0;
        cfg_entry_len_i = '0; cfg_tab_base_i = '0;
        setup_base();
        repeat (3) begin @(posedge clk); #1; end
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_hit", 32'(hit_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_ce", 32'(mem_ce_o), 32'd0);
        check("rst_val", val_addr_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // hit in way 0
        put_entry(192, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h01);
        lookup(32'd14, 8'd16, 4'd4, 16'd16, 32'd128);
        check("t1_model_val", exp_val, 32'd197);
        check("t1_hit", 32'(hit_o), 32'd1);
        check("t1_way", 32'(way_o), 32'd0);
        check("t1_val", val_addr_o, 32'd197);

        // hit in way 2 after two valid mismatches
        put_entry(192, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02);
        put_entry(208, 8'h03, 8'h0B, 8'h00, 8'h00, 8'h01);
        put_entry(224, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h01);
        lookup(32'd14, 8'd16, 4'd4, 16'd16, 32'd128);
        check("t2_model_way", 32'(exp_way), 32'd2);
        check("t2_hit", 32'(hit_o), 32'd1);
        check("t2_way", 32'(way_o), 32'd2);
        check("t2_val", val_addr_o, 32'd229);

        // miss: invalid-but-matching and valid-but-mismatching ways
        put_entry(192, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01);
        put_entry(208, 8'h01, 8'h0A, 8'h00, 8'h01, 8'h01);
        put_entry(224, 8'h02, 8'h0A, 8'h00, 8'h00, 8'h01);
        put_entry(240, 8'hFF, 8'h0A, 8'h00, 8'h00, 8'h00);
        lookup(32'd14, 8'd16, 4'd4, 16'd16, 32'd128);
        check("t3_model_hit", 32'(exp_hit), 32'd0);
        check("t3_ready", 32'(ready_o), 32'd1);
        check("t3_hit", 32'(hit_o), 32'd0);
        check("t3_val", val_addr_o, 32'd0);

        // illegal lengths
        lookup(32'd14, 8'd16, 4'd0, 16'd16, 32'd128);
        check("t4a_err", 32'(err_o), 32'd1);
        check("t4a_lat_ok", 32'(last_n <= 2), 32'd1);
        lookup(32'd14, 8'd16, 4'd9, 16'd16, 32'd128);
        check("t4b_err", 32'(err_o), 32'd1);
        check("t4b_lat_ok", 32'(last_n <= 2), 32'd1);

        // reset during entry scan, then a fresh lookup
        setup_base();
        put_entry(192, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h01);
        cfg_hdr_base_i = 32'd14; cfg_key_off_i = 8'd16; cfg_key_len_i = 4'd4;
        cfg_entry_len_i = 16'd16; cfg_tab_base_i = 32'd128;
        start_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(mem_ce_o && mem_addr_o == 32'd193) && n < 200);
        check("t5_reached_entry", 32'(mem_ce_o && mem_addr_o == 32'd193), 32'd1);
        rst_n = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        check("t5_ready", 32'(ready_o), 32'd0);
        check("t5_hit", 32'(hit_o), 32'd0);
        check("t5_err", 32'(err_o), 32'd0);
        check("t5_way", 32'(way_o), 32'd0);
        check("t5_val", val_addr_o, 32'd0);
        check("t5_ce", 32'(mem_ce_o), 32'd0);
        check("t5_addr", mem_addr_o, 32'd0);
        rst_n = 1'b1;
        hit_exp = 0;
        miss_exp = 0;
        @(posedge clk); #1;
        lookup(32'd14, 8'd16, 4'd4, 16'd16, 32'd128);
        check("t5b_hit", 32'(hit_o), 32'd1);
        check("t5b_val", val_addr_o, 32'd197);

        // randomized lookups over a low-entropy table
        for (int it = 0; it < 40; it++) begin
            hdr  = 32'($urandom_range(0, 255));
            off  = 8'($urandom_range(0, 255));
            len  = 4'($urandom_range(1, 8));
            elen = 16'($urandom_range(int'(len) + 1, 24));
            tab  = 32'($urandom_range(1024, 1200));
            if (it % 10 == 7) len = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(9, 15));
            for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom_range(0, 3));
            if (len >= 4'd1 && len <= 4'd8) begin
                if ($urandom_range(0, 2) != 0) begin
                    eb = bucket_of(hdr + 32'(off), len, elen, tab)
                       + 32'($urandom_range(0, WAYS - 1)) * 32'(elen);
                    mem[eb[11:0]] = 8'($urandom_range(0, 127) * 2 + ($urandom_range(0, 3) != 0 ? 1 : 0));
                    for (int j = 0; j < int'(len); j++)
                        mem[(eb + 32'd1 + 32'(j)) % 4096] = rd(hdr + 32'(off) + 32'(j));
                end
            end
            lookup(hdr, off, len, elen, tab);
        end

`ifdef MATCHER_STATS_EN
        check("hit_cnt", hit_cnt_o, 32'(hit_exp));
        check("miss_cnt", miss_cnt_o, 32'(miss_exp));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
